// File: rtl/stopwatch_pkg.sv
// Shared stopwatch definitions: FSM encodings and prescaler sizing helpers.
package stopwatch_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RUNNING = 2'd1;
  localparam logic [1:0] ST_PAUSED  = 2'd2;
  localparam logic [1:0] ST_LAP     = 2'd3;

  function automatic int presc_width(input int clk_hz, input int tick_hz);
    int div;
    div = clk_hz / tick_hz;
    return (div > 1) ? $clog2(div) : 1;
  endfunction

  function automatic logic is_counting(input logic [1:0] st);
    return (st == ST_RUNNING) || (st == ST_LAP);
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Raw button -> 2-flop synchronizer -> level debouncer -> one-cycle press on accepted rise.
// Press appears DEBOUNCE_CYCLES+2 cycles after the raw input is first sampled high.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic press_o
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          level_prev_q;
  logic          blocked_q, blocked_d;
  logic          press_q;

  always_ff @(posedge clk) begin
    sync1_q <= btn_i;
    sync2_q <= sync1_q;
  end

  // After reset the button must be seen released before any press can be accepted.
  always_comb begin
    cnt_d     = cnt_q;
    level_d   = level_q;
    blocked_d = blocked_q;
    if (blocked_q) begin
      cnt_d = '0;
      if (!sync2_q) blocked_d = 1'b0;
    end else if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d   = '0;
      level_d = sync2_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      blocked_q    <= 1'b1;
      press_q      <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      level_q      <= level_d;
      level_prev_q <= level_q;
      blocked_q    <= blocked_d;
      press_q      <= level_q & ~level_prev_q;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/stopwatch_control.sv
// Stopwatch controller: debounced start/stop and lap/reset buttons drive a 4-state FSM
// and a prescaler that emits a tick every CLK_HZ/TICK_HZ cycles while counting.
module stopwatch_control
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ          = 100_000_000,
  parameter int TICK_HZ         = 1,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_start_stop,
  input  logic       btn_lap_reset,
  output logic       tick,
  output logic       clear,
  output logic       running,
  output logic       lap_hold,
  output logic [1:0] state
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = presc_width(CLK_HZ, TICK_HZ);
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

  logic          ss_press, lr_press;
  logic [1:0]    state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          clear_q, clear_d;
  logic          running_q, lap_hold_q;
  logic          counting_now;
  logic          tick_w;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start_stop (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_i  (btn_start_stop),
    .press_o(ss_press)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_lap_reset (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_i  (btn_lap_reset),
    .press_o(lr_press)
  );

  // start_stop has priority; a simultaneous lap_reset press is dropped.
  always_comb begin
    state_d = state_q;
    clear_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ss_press)      state_d = ST_RUNNING;
        else if (lr_press) clear_d = 1'b1;
      end
      ST_RUNNING: begin
        if (ss_press)      state_d = ST_PAUSED;
        else if (lr_press) state_d = ST_LAP;
      end
      ST_LAP: begin
        if (ss_press)      state_d = ST_PAUSED;
        else if (lr_press) state_d = ST_RUNNING;
      end
      ST_PAUSED: begin
        if (ss_press) begin
          state_d = ST_RUNNING;
        end else if (lr_press) begin
          state_d = ST_IDLE;
          clear_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Only count on cycles that stay in a counting state, so a pause freezes the
  // prescaler before it can tick and a resume continues from the frozen value.
  always_comb begin
    counting_now = is_counting(state_q) && is_counting(state_d);
    tick_w       = counting_now && (presc_q == PRESC_LAST);
    presc_d      = presc_q;
    if (state_d == ST_IDLE)  presc_d = '0;
    else if (tick_w)         presc_d = '0;
    else if (counting_now)   presc_d = presc_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      presc_q    <= '0;
      clear_q    <= 1'b0;
      running_q  <= 1'b0;
      lap_hold_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      clear_q    <= clear_d;
      running_q  <= is_counting(state_d);
      lap_hold_q <= (state_d == ST_LAP);
    end
  end

  assign tick     = tick_w;
  assign clear    = clear_q;
  assign running  = running_q;
  assign lap_hold = lap_hold_q;
  assign state    = state_q;

endmodule

// File: tb/tb_stopwatch_control.sv
// Directed bench for stopwatch_control with a cycle-level reference model and literal timing checks.
module tb_stopwatch_control;

  localparam int CLK_HZ  = 100;
  localparam int TICK_HZ = 10;
  localparam int DB      = 4;
  localparam int DIV     = CLK_HZ / TICK_HZ;
  localparam int HN      = 2048;
  localparam int BLOCKED = 1 << 30;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       b_ss = 1'b0;
  logic       b_lr = 1'b0;
  logic       tick, clear, running, lap_hold;
  logic [1:0] state;

  always #5 clk = ~clk;

  stopwatch_control #(
    .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_start_stop(b_ss), .btn_lap_reset(b_lr),
    .tick(tick), .clear(clear), .running(running), .lap_hold(lap_hold), .state(state)
  );

  int n_chk = 0;
  int n_bad = 0;
  int cyc = 0;

  // Reference model state
  int hist_ss[HN];
  int hist_lr[HN];
  int st_h[HN];
  int tk_h[HN];
  int cl_h[HN];
  int tbl_ss[4] = '{1, 2, 1, 2};
  int tbl_lr[4] = '{0, 3, 0, 1};
  int m_state = 0;
  int m_phase = 0;
  int m_clear = 0;
  int m_tick = 0;
  int acc[2];
  int ub[2];
  int rose[2];
  int pv[2];
  int nxt;
  int ok;

  task automatic cmp(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, act, exp);
    end
  endtask

  function automatic int counting(input int s);
    return (s == 1 || s == 3) ? 1 : 0;
  endfunction

  function automatic int next_st(input int s, input int ss, input int lr);
    if (ss != 0) return tbl_ss[s];
    if (lr != 0) return tbl_lr[s];
    return s;
  endfunction

  function automatic int raw_at(input int b, input int e);
    if (e < 1 || e >= HN) return 0;
    return (b == 0) ? hist_ss[e] : hist_lr[e];
  endfunction

  function automatic int hsum(input int which, input int a, input int b);
    int s = 0;
    for (int k = a; k <= b; k++) begin
      if (k >= 0 && k < HN) s += (which == 0) ? tk_h[k] : (which == 1) ? cl_h[k] : (st_h[k] != 0 ? 1 : 0);
    end
    return s;
  endfunction

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (cyc < HN) begin
      hist_ss[cyc] = int'(b_ss);
      hist_lr[cyc] = int'(b_lr);
    end
    if (!rst_n) begin
      m_state = 0;
      m_phase = 0;
      m_clear = 0;
      for (int b = 0; b < 2; b++) begin
        acc[b] = 0; ub[b] = BLOCKED; rose[b] = 0; pv[b] = 0;
      end
    end else begin
      nxt = next_st(m_state, pv[0], pv[1]);
      m_clear = (pv[0] == 0 && pv[1] != 0 && nxt == 0) ? 1 : 0;
      if (nxt == 0) m_phase = 0;
      else if (counting(m_state) != 0 && counting(nxt) != 0) m_phase = (m_phase + 1) % DIV;
      m_state = nxt;
      for (int b = 0; b < 2; b++) begin
        pv[b] = rose[b];
        rose[b] = 0;
        if (ub[b] == BLOCKED) begin
          if (raw_at(b, cyc - 2) == 0) ub[b] = cyc;
        end else begin
          // accept when the last DB synchronized samples all disagree with the accepted level
          ok = 1;
          for (int m = cyc - DB + 1; m <= cyc; m++)
            if (m <= ub[b] || raw_at(b, m - 2) == acc[b]) ok = 0;
          if (ok != 0) begin
            acc[b] = 1 - acc[b];
            rose[b] = acc[b];
          end
        end
      end
    end
    m_tick = (counting(m_state) != 0 && counting(next_st(m_state, pv[0], pv[1])) != 0
              && m_phase == DIV - 1) ? 1 : 0;
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      cmp("tick", int'(tick), m_tick);
      cmp("clear", int'(clear), m_clear);
      cmp("running", int'(running), counting(m_state));
      cmp("lap_hold", int'(lap_hold), (m_state == 3) ? 1 : 0);
      cmp("state", int'(state), m_state);
      if (cyc < HN) begin
        st_h[cyc] = int'(state);
        tk_h[cyc] = int'(tick);
        cl_h[cyc] = int'(clear);
      end
    end
  end

  // Called at a negedge; buttons are first sampled at edge e = cyc+1.
  task automatic press(input bit ss, input bit lr, input int hold, input int gap, output int e);
    b_ss = ss;
    b_lr = lr;
    e = cyc + 1;
    repeat (hold) @(negedge clk);
    b_ss = 1'b0;
    b_lr = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  int e0, e1, e2, e3, e4, e5, e6, e7, e8, e9, e10, rr;

  initial begin
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    cmp("reset_outputs", int'({tick, clear, running, lap_hold, state}), 0);
    rst_n = 1'b1;

    // 3 high, 1 low, 3 high glitch never reaches DB stable samples
    b_ss = 1'b1; repeat (3) @(negedge clk);
    b_ss = 1'b0; repeat (1) @(negedge clk);
    b_ss = 1'b1; repeat (3) @(negedge clk);
    b_ss = 1'b0; repeat (15) @(negedge clk);
    cmp("glitch_state", int'(state), 0);
    cmp("glitch_no_run", hsum(2, 5, cyc - 1), 0);

    press(1'b1, 1'b0, 20, 10, e0);
    cmp("start_before", st_h[e0 + 6], 0);
    cmp("start_state", st_h[e0 + 7], 1);
    cmp("tick_none_early", hsum(0, e0, e0 + 15), 0);
    cmp("tick_first", tk_h[e0 + 16], 1);
    cmp("tick_second", tk_h[e0 + 26], 1);

    // press visible at e0+44 where the prescaler reads 7
    while (cyc < e0 + 37) @(negedge clk);
    press(1'b1, 1'b0, 8, 18, e1);
    cmp("pause_state", st_h[e1 + 7], 2);
    press(1'b1, 1'b0, 8, 8, e2);
    cmp("resume_state", st_h[e2 + 7], 1);
    cmp("paused_no_tick", hsum(0, e1 + 7, e2 + 8), 0);
    cmp("resume_tick", tk_h[e2 + 9], 1);

    press(1'b0, 1'b1, 8, 8, e3);
    repeat (2) @(negedge clk);
    cmp("lap_state", st_h[e3 + 7], 3);
    cmp("lap_ticks", hsum(0, e3 + 7, e3 + 16), 1);
    press(1'b0, 1'b1, 8, 8, e4);
    cmp("unlap_state", st_h[e4 + 7], 1);

    press(1'b1, 1'b0, 8, 8, e5);
    cmp("pause2_state", st_h[e5 + 7], 2);
    press(1'b1, 1'b1, 8, 8, e6);
    cmp("both_state", st_h[e6 + 7], 1);
    cmp("both_no_clear", hsum(1, e6, e6 + 15), 0);
    press(1'b1, 1'b0, 8, 8, e7);
    press(1'b0, 1'b1, 8, 8, e8);
    cmp("reset_state", st_h[e8 + 7], 0);
    cmp("clear_pulse", cl_h[e8 + 7], 1);
    cmp("clear_count", hsum(1, e8, e8 + 15), 1);

    // start from IDLE again: zeroed prescaler gives the first tick 16 cycles after the edge
    b_ss = 1'b1;
    e9 = cyc + 1;
    repeat (20) @(negedge clk);
    cmp("restart_state", st_h[e9 + 7], 1);
    cmp("restart_tick", tk_h[e9 + 16], 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    rr = cyc;
    cmp("midrst_outputs", int'({tick, clear, running, lap_hold, state}), 0);
    repeat (15) @(negedge clk);
    cmp("held_no_press", hsum(2, rr, cyc - 1), 0);
    b_ss = 1'b0;
    repeat (8) @(negedge clk);
    press(1'b1, 1'b0, 8, 8, e10);
    cmp("repress_state", st_h[e10 + 7], 1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d got=running want=finished", cyc);
    $fatal(1);
  end

endmodule

// File: doc/stopwatch_control.md
STOPWATCH_CONTROL -- requirements
Module: stopwatch_control

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100_000_000: board clock frequency.
REQ-002 SHALL have parameter TICK_HZ, default 1: frequency of the count-enable pulse.
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 1_000_000: consecutive stable samples required to accept a button level.
REQ-004 SHALL have port clk, input, 1: single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-006 SHALL have port btn_start_stop, input, 1: raw asynchronous button, active-high.
REQ-007 SHALL have port btn_lap_reset, input, 1: raw asynchronous button, active-high.
REQ-008 SHALL have port tick, output, 1: one-cycle count-enable pulse for the downstream seconds counters.
REQ-009 SHALL have port clear, output, 1: one-cycle pulse that zeroes the downstream counters.
REQ-010 SHALL have port running, output, 1: high in RUNNING or LAP.
REQ-011 SHALL have port lap_hold, output, 1: high in LAP; freezes the display value.
REQ-012 SHALL have port state, output, 2: current FSM state encoding.

Function
REQ-013 SHALL pass each button through a 2-flop synchronizer, then a debouncer.
REQ-014 The debouncer SHALL accept a new level only after DEBOUNCE_CYCLES consecutive synchronized samples equal to it.
REQ-015 SHALL reset the debounce counter on any sample differing from the candidate level.
REQ-016 SHALL emit a one-cycle press event on an accepted 0->1 transition only; release events are ignored.
REQ-017 The press event SHALL assert exactly DEBOUNCE_CYCLES+2 cycles after the first edge that samples the raw input high, provided the input stays high.
REQ-018 SHALL implement states IDLE=2'd0, RUNNING=2'd1, PAUSED=2'd2, LAP=2'd3; the state register updates on the edge after the press event.
REQ-019 IDLE: start_stop -> RUNNING; lap_reset -> IDLE and pulse clear.
REQ-020 RUNNING: start_stop -> PAUSED; lap_reset -> LAP.
REQ-021 LAP: start_stop -> PAUSED, which drops lap_hold; lap_reset -> RUNNING.
REQ-022 PAUSED: start_stop -> RUNNING; lap_reset -> IDLE and pulse clear.
REQ-023 On simultaneous press events, start_stop SHALL win and lap_reset SHALL be discarded.
REQ-024 The prescaler SHALL be a counter of width clog2(CLK_HZ/TICK_HZ) counting 0..CLK_HZ/TICK_HZ-1.
REQ-025 The prescaler SHALL increment in RUNNING and LAP, hold in PAUSED, and be zero in IDLE.
REQ-026 tick SHALL be high for one cycle when the prescaler equals CLK_HZ/TICK_HZ-1 in RUNNING or LAP; the prescaler then wraps to 0.
REQ-027 tick SHALL never assert in IDLE or PAUSED, including the cycle a pause is entered.
REQ-028 clear SHALL assert in the same cycle the state register is written IDLE by lap_reset; clear and tick SHALL never be high together.
REQ-029 running, lap_hold and state SHALL be registered outputs decoded from the state register.

Reset
REQ-030 With rst_n low at a clock edge, the block SHALL enter IDLE.
REQ-031 That edge SHALL zero the prescaler and both debounce counters, set accepted levels to 0, and drive tick=0, clear=0, running=0, lap_hold=0, state=0.
REQ-032 Reset mid-operation SHALL discard in-flight debounce progress.
REQ-033 A button held through reset release SHALL produce no press until released and re-pressed.

Structure
REQ-034 stopwatch_pkg SHALL hold the state encodings and the prescaler-width constant function.
REQ-035 Synchronizer plus debouncer plus edge detect SHALL be one sub-module, button_debouncer, instantiated twice.

Verification (bench parameters: CLK_HZ=100, TICK_HZ=10, DEBOUNCE_CYCLES=4)
REQ-036 Reset, then start_stop held high 20 cycles -> press event at cycle 6; state=1 at cycle 7; tick every 10 cycles thereafter.
REQ-037 Button glitch of 3 cycles high, 1 low, 3 high -> no press event; state stays 0.
REQ-038 Run, pause at prescaler=7, resume -> first tick after resume arrives 2 cycles after the prescaler restarts; no tick while PAUSED.
REQ-039 Run, lap_reset -> state=3, lap_hold=1, ticks continue; lap_reset again -> state=1, lap_hold=0.
REQ-040 PAUSED with both buttons pressing on the same cycle -> state=1, no clear; then a lap_reset press from PAUSED -> one clear pulse, state=0, prescaler=0.
REQ-041 rst_n low for 1 cycle while RUNNING with start_stop held -> all outputs 0, state=0; no press event until release and re-press.
